latch_sync_filter: RTL and testbench

//  Downstream stage for the level-sensitive D latch output. Brings the latch q
//  (asynchronous to clk) into the clk domain through a flop synchronizer.

---
 rtl/latch_sync_filter.sv | 145 ++++++++++++++
 tb/tb_latch_sync_filter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_sync_filter.sv
// Synchronizes the latch q into the clk domain, filters glitches shorter than
// FILT_CYCLES clocks, emits rise/fall pulses and counts accepted rising events.
module latch_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_async,
  input  logic             clr_cnt,
  output logic             q_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_ovf
);

  localparam int SW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(FILT_CYCLES - 1);
  localparam bit SKIP_CHK = (FILT_CYCLES == 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHK_HIGH,
    STABLE_HIGH,
    CHK_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_nxt;
  logic [SW-1:0]          stab_cnt, stab_nxt;
  logic                   q_nxt, rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_async};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STABLE_LOW;
      stab_cnt   <= '0;
      q_filt     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      stab_cnt   <= stab_nxt;
      q_filt     <= q_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // A CHK state counts consecutive cycles at the new level; any return to the
  // old level restarts the count from scratch.
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab_cnt;
    q_nxt     = q_filt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (s) begin
          if (SKIP_CHK) begin
            state_nxt = STABLE_HIGH;
            q_nxt     = 1'b1;
            rise_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_HIGH;
            stab_nxt  = SW'(1);
          end
        end
      end
      CHK_HIGH: begin
        if (!s) begin
          state_nxt = STABLE_LOW;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = STABLE_HIGH;
          stab_nxt  = '0;
          q_nxt     = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          stab_nxt = stab_cnt + SW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          if (SKIP_CHK) begin
            state_nxt = STABLE_LOW;
            q_nxt     = 1'b0;
            fall_nxt  = 1'b1;
          end else begin
            state_nxt = CHK_LOW;
            stab_nxt  = SW'(1);
          end
        end
      end
      CHK_LOW: begin
        if (s) begin
          state_nxt = STABLE_HIGH;
          stab_nxt  = '0;
        end else if (stab_cnt == STAB_LAST) begin
          state_nxt = STABLE_LOW;
          stab_nxt  = '0;
          q_nxt     = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          stab_nxt = stab_cnt + SW'(1);
        end
      end
      default: begin
        state_nxt = STABLE_LOW;
        stab_nxt  = '0;
      end
    endcase
  end

  // Clear takes priority, so a rise landing on a clear cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (clr_cnt) begin
      edge_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (rise_pulse) begin
      if (&edge_cnt) begin
        cnt_ovf <= 1'b1;
      end else begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_latch_sync_filter.sv
// Drives three configurations of latch_sync_filter from shared inputs and
// compares every output each cycle against a run-length reference model.
module tb_latch_sync_filter;

  logic clk;
  logic rst_n;
  logic d_async;
  logic clr_cnt;

  logic       q_a, rise_a, fall_a, ovf_a;
  logic [7:0] cnt_a;
  logic       q_b, rise_b, fall_b, ovf_b;
  logic [1:0] cnt_b;
  logic       q_c, rise_c, fall_c, ovf_c;
  logic [2:0] cnt_c;

  int compared   = 0;
  int mismatched = 0;

  latch_sync_filter #(.SYNC_STAGES(2), .FILT_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .d_async(d_async), .clr_cnt(clr_cnt),
    .q_filt(q_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .edge_cnt(cnt_a), .cnt_ovf(ovf_a)
  );

  latch_sync_filter #(.SYNC_STAGES(2), .FILT_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .d_async(d_async), .clr_cnt(clr_cnt),
    .q_filt(q_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .edge_cnt(cnt_b), .cnt_ovf(ovf_b)
  );

  latch_sync_filter #(.SYNC_STAGES(3), .FILT_CYCLES(1), .CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .d_async(d_async), .clr_cnt(clr_cnt),
    .q_filt(q_c), .rise_pulse(rise_c), .fall_pulse(fall_c),
    .edge_cnt(cnt_c), .cnt_ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: s is the input as sampled SYNC edges earlier; a new level
  // is accepted once s has differed from q_filt for FILT consecutive edges.
  int          p_sync[3] = '{2, 2, 3};
  int          p_filt[3] = '{4, 4, 1};
  int          p_cntw[3] = '{8, 2, 3};
  logic [15:0] m_hist[3];
  int          m_run[3];
  int          m_cnt[3];
  bit          m_q[3], m_rise[3], m_fall[3], m_ovf[3];

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k] = '0; m_run[k] = 0; m_cnt[k] = 0;
      m_q[k] = 0; m_rise[k] = 0; m_fall[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic modelStep(input int k);
    bit s;
    int max;
    s   = m_hist[k][p_sync[k]-1];
    max = (1 << p_cntw[k]) - 1;
    m_hist[k] = {m_hist[k][14:0], d_async};
    if (clr_cnt) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
    end else if (m_rise[k]) begin
      if (m_cnt[k] == max) m_ovf[k] = 1;
      else m_cnt[k] = m_cnt[k] + 1;
    end
    m_rise[k] = 0;
    m_fall[k] = 0;
    if (s != m_q[k]) m_run[k] = m_run[k] + 1;
    else m_run[k] = 0;
    if (m_run[k] == p_filt[k]) begin
      m_q[k] = s;
      if (s) m_rise[k] = 1;
      else m_fall[k] = 1;
      m_run[k] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else for (int k = 0; k < 3; k++) modelStep(k);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("a_q", q_a, m_q[0]);
    checkOutput("a_rise", rise_a, m_rise[0]);
    checkOutput("a_fall", fall_a, m_fall[0]);
    checkOutput("a_cnt", cnt_a, m_cnt[0]);
    checkOutput("a_ovf", ovf_a, m_ovf[0]);
    checkOutput("b_q", q_b, m_q[1]);
    checkOutput("b_rise", rise_b, m_rise[1]);
    checkOutput("b_fall", fall_b, m_fall[1]);
    checkOutput("b_cnt", cnt_b, m_cnt[1]);
    checkOutput("b_ovf", ovf_b, m_ovf[1]);
    checkOutput("c_q", q_c, m_q[2]);
    checkOutput("c_rise", rise_c, m_rise[2]);
    checkOutput("c_fall", fall_c, m_fall[2]);
    checkOutput("c_cnt", cnt_c, m_cnt[2]);
    checkOutput("c_ovf", ovf_c, m_ovf[2]);
    checkOutput("pulse_excl", rise_a & fall_a, 0);
  endtask

  task automatic applyStimulus(input logic d, input logic clr);
    d_async = d;
    clr_cnt = clr;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkAll();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hold;
    bit found;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(4);
    checkOutput("rst_q", q_a, 0);
    checkOutput("rst_cnt", cnt_a, 0);
    checkOutput("rst_ovf", ovf_a, 0);

    // Clean rise: visible on edge 6 (edge 4 for the 3-stage, unfiltered copy)
    applyStimulus(1'b1, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      tick(1);
      checkOutput($sformatf("rise_q_e%0d", n), q_a, (n >= 6) ? 1 : 0);
      checkOutput($sformatf("rise_p_e%0d", n), rise_a, (n == 6) ? 1 : 0);
      checkOutput($sformatf("rise_cnt_e%0d", n), cnt_a, (n >= 7) ? 1 : 0);
      checkOutput($sformatf("c_rise_q_e%0d", n), q_c, (n >= 4) ? 1 : 0);
    end
    tick(3);

    // Fall: same latency, counter untouched
    applyStimulus(1'b0, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      tick(1);
      checkOutput($sformatf("fall_q_e%0d", n), q_a, (n >= 6) ? 0 : 1);
      checkOutput($sformatf("fall_p_e%0d", n), fall_a, (n == 6) ? 1 : 0);
      checkOutput($sformatf("fall_cnt_e%0d", n), cnt_a, 1);
    end
    tick(3);

    // Glitch of 3 cycles is rejected by the FILT=4 copies
    applyStimulus(1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b0, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      tick(1);
      checkOutput("glitch_q", q_a, 0);
      checkOutput("glitch_rise", rise_a, 0);
      checkOutput("glitch_fall", fall_a, 0);
    end
    checkOutput("glitch_cnt", cnt_a, 1);

    // Asynchronous reset mid-cycle while high, then release with d still high
    applyStimulus(1'b1, 1'b0);
    tick(10);
    checkOutput("pre_rst_q", q_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_q", q_a, 0);
    checkOutput("arst_cnt", cnt_a, 0);
    checkOutput("arst_ovf", ovf_a, 0);
    checkOutput("arst_b_q", q_b, 0);
    checkOutput("arst_c_q", q_c, 0);
    checkOutput("arst_c_cnt", cnt_c, 0);
    tick(2);
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick(1);
      checkOutput($sformatf("rel_q_e%0d", n), q_a, (n >= 6) ? 1 : 0);
      checkOutput($sformatf("rel_cnt_e%0d", n), cnt_a, (n >= 7) ? 1 : 0);
    end

    // Saturation of the 2-bit counter
    for (int r = 0; r < 5; r++) begin
      applyStimulus(1'b0, 1'b0);
      tick(10);
      applyStimulus(1'b1, 1'b0);
      tick(10);
    end
    checkOutput("sat_cnt", cnt_b, 3);
    checkOutput("sat_ovf", ovf_b, 1);
    checkOutput("sat_a_cnt", cnt_a, 6);

    // Clear coincident with a rise pulse drops that rise
    applyStimulus(1'b0, 1'b0);
    tick(10);
    applyStimulus(1'b1, 1'b0);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick(1);
      if (m_rise[1]) found = 1;
    end
    checkOutput("clr_wait", found, 1);
    applyStimulus(1'b1, 1'b1);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clr_cnt", cnt_b, 0);
    checkOutput("clr_ovf", ovf_b, 0);
    tick(2);
    checkOutput("clr_hold", cnt_b, 0);

    // Random toggling at varied widths
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        d_async = ~d_async;
        hold = $urandom_range(1, 8);
      end
      hold--;
      clr_cnt = ($urandom_range(0, 49) == 0);
      tick(1);
      checkOutput("no_x", {31'd0, $isunknown({q_a, rise_a, fall_a, cnt_a, ovf_a,
                                             q_b, cnt_b, q_c, cnt_c})}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
